// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared widths, state encoding and data types for the nonce search controller
//
// Purpose : common constants and types for the nonce search controller.
// Ports   : none (package).

package miner_pkg;

    localparam int SHA_MSG_W = 640;
    localparam int HDR_W     = 608;
    localparam int NONCE_W   = 32;
    localparam int HASH_W    = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    typedef logic [HASH_W-1:0]  hash_t;
    typedef logic [NONCE_W-1:0] nonce_t;
    typedef logic [HDR_W-1:0]   header_t;

endpackage

// File: rtl/nonce_search_controller_if.sv
// rtl/nonce_search_controller_if.sv - message/launch/digest bus between the search controller and the SHA core
//
// Purpose : bundles the SHA core handshake.
// Signals : sha_msg      - 640-bit message presented to the core
//           sha_begin    - one-cycle launch pulse
//           sha_complete - digest valid pulse from the core
//           sha_hash     - digest from the core
// Modports: master (search controller), slave (SHA core).

interface nonce_search_controller_if #(
    parameter int MSG_W = miner_pkg::SHA_MSG_W,
    parameter int DIG_W = miner_pkg::HASH_W
);

    logic [MSG_W-1:0] sha_msg;
    logic             sha_begin;
    logic             sha_complete;
    logic [DIG_W-1:0] sha_hash;

    modport master (
        output sha_msg,
        output sha_begin,
        input  sha_complete,
        input  sha_hash
    );

    modport slave (
        input  sha_msg,
        input  sha_begin,
        output sha_complete,
        output sha_hash
    );

endinterface

// File: rtl/nonce_range_counter.sv
// rtl/nonce_range_counter.sv - current nonce register with load, wrapping increment and last-nonce flag
//
// Purpose : holds the nonce under test and the inclusive end of the range.
// Ports   : clk, n_rst          - clock, async active-low reset
//           load, loadStart,
//           loadEnd             - capture a new range (nonce_q <= loadStart)
//           inc                 - advance nonce_q by one, wrapping through 0
//           nonce_q             - current nonce
//           isLast              - nonce_q equals the captured end nonce

module nonce_range_counter #(
    parameter int NONCE_W = miner_pkg::NONCE_W
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               load,
    input  logic               inc,
    input  logic [NONCE_W-1:0] loadStart,
    input  logic [NONCE_W-1:0] loadEnd,
    output logic [NONCE_W-1:0] nonce_q,
    output logic               isLast
);

    logic [NONCE_W-1:0] nonceEndQ;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            nonce_q   <= '0;
            nonceEndQ <= '0;
        end else if (load) begin
            nonce_q   <= loadStart;
            nonceEndQ <= loadEnd;
        end else if (inc) begin
            // Natural modulo-2^NONCE_W wrap lets an end below the start
            // walk through zero.
            nonce_q <= nonce_q + NONCE_W'(1);
        end
    end

    assign isLast = (nonce_q == nonceEndQ);

endmodule

// File: rtl/nonce_search_controller.sv
// rtl/nonce_search_controller.sv - iterates nonces through the SHA core and stops on the first digest below target

module nonce_search_controller #(
    parameter int HDR_W          = miner_pkg::HDR_W,
    parameter int NONCE_W        = miner_pkg::NONCE_W,
    parameter int HASH_W         = miner_pkg::HASH_W,
    parameter int COUNT_W        = 32,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [HDR_W-1:0]          header_prefix,
    input  logic [NONCE_W-1:0]        nonce_start,
    input  logic [NONCE_W-1:0]        nonce_end,
    input  logic [HASH_W-1:0]         target,
    output logic [HDR_W+NONCE_W-1:0]  sha_msg,
    output logic                      sha_begin,
    input  logic                      sha_complete,
    input  logic [HASH_W-1:0]         sha_hash,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic [NONCE_W-1:0]        found_nonce,
    output logic [HASH_W-1:0]         found_hash,
    output logic [COUNT_W-1:0]        hash_count,
    output logic                      timeout_err
);

    import miner_pkg::*;

    state_t             state;
    logic [HDR_W-1:0]   hdr_q;
    logic [HASH_W-1:0]  target_q;
    logic [HASH_W-1:0]  hash_q;
    logic [NONCE_W-1:0] nonce_q;
    logic               isLast;
    logic               outstanding;
    logic               shaBeginQ;
    logic               startTake;
    logic               hit;
    logic               cntInc;

    assign startTake = start && !abort &&
                       (state == S_IDLE || state == S_FOUND || state == S_EXHAUSTED);
    assign hit       = (hash_q < target_q);
    assign cntInc    = !abort && (state == S_CHECK) && !hit && !isLast;

    nonce_range_counter #(
        .NONCE_W (NONCE_W)
    ) u_range (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (startTake),
        .inc       (cntInc),
        .loadStart (nonce_start),
        .loadEnd   (nonce_end),
        .nonce_q   (nonce_q),
        .isLast    (isLast)
    );

    assign sha_msg   = {hdr_q, nonce_q};
    assign sha_begin = shaBeginQ;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            outstanding <= 1'b0;
        end else if (shaBeginQ) begin
            outstanding <= 1'b1;
        end else if (sha_complete) begin
            outstanding <= 1'b0;
        end
    end

`ifdef MINER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] waitCnt;
    logic            timeoutErrQ;
    assign timeout_err = timeoutErrQ;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            hdr_q       <= '0;
            target_q    <= '0;
            hash_q      <= '0;
            shaBeginQ   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            hash_count  <= '0;
`ifdef MINER_TIMEOUT_EN
            waitCnt     <= '0;
            timeoutErrQ <= 1'b0;
`endif
        end else if (abort) begin
            state     <= S_IDLE;
            shaBeginQ <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
`ifdef MINER_TIMEOUT_EN
            timeoutErrQ <= 1'b0;
`endif
        end else if (startTake) begin
            state      <= S_ARM;
            hdr_q      <= header_prefix;
            target_q   <= target;
            busy       <= 1'b1;
            done       <= 1'b0;
            found      <= 1'b0;
            hash_count <= '0;
`ifdef MINER_TIMEOUT_EN
            timeoutErrQ <= 1'b0;
`endif
        end else begin
            case (state)
                S_ARM: begin
                    if (!outstanding) begin
                        state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    shaBeginQ <= 1'b1;
                    state     <= S_WAIT;
`ifdef MINER_TIMEOUT_EN
                    waitCnt   <= '0;
`endif
                end
                S_WAIT: begin
                    shaBeginQ <= 1'b0;
                    if (sha_complete && outstanding) begin
                        hash_q <= sha_hash;
                        if (hash_count != {COUNT_W{1'b1}}) begin
                            hash_count <= hash_count + COUNT_W'(1);
                        end
                        state <= S_CHECK;
                    end
`ifdef MINER_TIMEOUT_EN
                    else if (waitCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeoutErrQ <= 1'b1;
                        done        <= 1'b1;
                        found       <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_EXHAUSTED;
                    end else begin
                        waitCnt <= waitCnt + TO_W'(1);
                    end
`endif
                end
                S_CHECK: begin
                    if (hit) begin
                        found_nonce <= nonce_q;
                        found_hash  <= hash_q;
                        done        <= 1'b1;
                        found       <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_FOUND;
                    end else if (isLast) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_EXHAUSTED;
                    end else begin
                        state <= S_LAUNCH;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_search_controller.sv
// tb/tb_nonce_search_controller.sv - scoreboard bench for nonce_search_controller with a behavioural SHA stub

module tb_nonce_search_controller;

    import miner_pkg::*;

    logic    clk = 1'b0;
    logic    n_rst = 1'b0;
    logic    start = 1'b0;
    logic    abort = 1'b0;
    header_t header_prefix = '0;
    nonce_t  nonce_start = '0;
    nonce_t  nonce_end = '0;
    hash_t   target = '0;
    logic    busy, done, found, timeout_err;
    nonce_t  found_nonce;
    hash_t   found_hash;
    logic [31:0] hash_count;

    logic [639:0] sha_msg;
    logic         sha_begin;
    logic         sha_complete;
    hash_t        sha_hash;

    always #5 clk = ~clk;

    nonce_search_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .abort         (abort),
        .header_prefix (header_prefix),
        .nonce_start   (nonce_start),
        .nonce_end     (nonce_end),
        .target        (target),
        .sha_msg       (sha_msg),
        .sha_begin     (sha_begin),
        .sha_complete  (sha_complete),
        .sha_hash      (sha_hash),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .found_nonce   (found_nonce),
        .found_hash    (found_hash),
        .hash_count    (hash_count),
        .timeout_err   (timeout_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    int     hashMode = 0;
    hash_t  stubConst = '0;
    logic [31:0] salt = 32'h1234_5678;
    int     stubLat = 2;
    bit     stubHang = 1'b0;

    function automatic hash_t hashFn(input nonce_t n);
        logic [31:0] w;
        if (hashMode == 1) return stubConst;
        w = (n * 32'h9E37_79B1) ^ salt;
        return {w, ~w, w ^ 32'hA5A5_A5A5, {5{w}}};
    endfunction

    bit    pend = 1'b0;
    int    pendCnt = 0;
    hash_t pendHash = '0;

    initial begin
        sha_complete = 1'b0;
        sha_hash     = '0;
        forever begin
            @(negedge clk);
            sha_complete = 1'b0;
            if (pend && !stubHang) begin
                if (pendCnt == 0) begin
                    sha_complete = 1'b1;
                    sha_hash     = pendHash;
                    pend = 1'b0;
                end else begin
                    pendCnt--;
                end
            end
            if (sha_begin) begin
                if (pend) flag("sha_begin while a hash is still in flight");
                pend     = 1'b1;
                pendCnt  = stubLat - 1;
                pendHash = hashFn(sha_msg[31:0]);
            end
        end
    end

    typedef struct {
        bit          fnd;
        nonce_t      n;
        hash_t       h;
        logic [31:0] cnt;
        bit          to;
    } res_t;

    logic [639:0] expMsgQ[$];
    res_t         expResQ[$];
    nonce_t       lastN = '0;
    hash_t        lastH = '0;

    task automatic modelSearch(input header_t p, input nonce_t s, input nonce_t e, input hash_t t);
        nonce_t n;
        int     c;
        res_t   r;
        n = s;
        c = 0;
        r.fnd = 1'b0;
        r.to  = 1'b0;
        r.n   = lastN;
        r.h   = lastH;
        forever begin
            expMsgQ.push_back({p, n});
            c++;
            if (hashFn(n) < t) begin
                r.fnd = 1'b1;
                r.n   = n;
                r.h   = hashFn(n);
                break;
            end
            if (n == e || c >= 64) break;
            n = n + 32'd1;
        end
        r.cnt = c;
        lastN = r.n;
        lastH = r.h;
        expResQ.push_back(r);
    endtask

    initial begin
        bit           prevDone;
        logic [639:0] m;
        res_t         r;
        prevDone = 1'b0;
        forever begin
            @(negedge clk);
            if (sha_begin) begin
                if (expMsgQ.size() == 0) begin
                    flag("unexpected sha_begin");
                end else begin
                    m = expMsgQ.pop_front();
                    check("sha_msg", sha_msg, m);
                    check("busy at launch", busy, 1);
                end
            end
            if (done && !prevDone) begin
                if (expResQ.size() == 0) begin
                    flag("unexpected done");
                end else begin
                    r = expResQ.pop_front();
                    check("found", found, r.fnd);
                    check("found_nonce", found_nonce, r.n);
                    check("found_hash", found_hash, r.h);
                    check("hash_count", hash_count, r.cnt);
                    check("timeout_err", timeout_err, r.to);
                    check("busy at done", busy, 0);
                end
            end
            prevDone = done;
        end
    end

    task automatic launch(input header_t p, input nonce_t s, input nonce_t e, input hash_t t, input bit useModel);
        @(negedge clk);
        header_prefix = p;
        nonce_start   = s;
        nonce_end     = e;
        target        = t;
        start         = 1'b1;
        if (useModel) modelSearch(p, s, e, t);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int c;
        c = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (!done) flag(name);
    endtask

    function automatic header_t randHdr();
        header_t h;
        for (int i = 0; i < 19; i++) h[i*32 +: 32] = $urandom;
        return h;
    endfunction

    initial begin
        header_t p;
        nonce_t  s;
        hash_t   t;
        int      c;

        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset found", found, 0);
        check("reset found_nonce", found_nonce, 0);
        check("reset found_hash", found_hash, 0);
        check("reset hash_count", hash_count, 0);
        check("reset timeout_err", timeout_err, 0);
        check("reset sha_begin", sha_begin, 0);
        check("reset sha_msg", sha_msg, 0);
        n_rst = 1'b1;
        @(negedge clk);

        launch('0, 32'd5, 32'd9, '1, 1);
        waitDone("single hit done timeout");

        launch(randHdr(), 32'd10, 32'd13, '0, 1);
        waitDone("exhaustion done timeout");

        stubLat = 4;
        launch(randHdr(), 32'hFFFF_FFFE, 32'd1, '0, 1);
        waitDone("wrap done timeout");

        hashMode = 1;
        t = {1'b1, 255'(($urandom << 7) ^ $urandom)};
        stubConst = t;
        launch(randHdr(), 32'd7, 32'd7, t, 1);
        waitDone("equality done timeout");
        stubConst = t - 256'd1;
        launch(randHdr(), 32'd8, 32'd8, t, 1);
        waitDone("target-1 done timeout");
        hashMode = 0;

        stubLat = 20;
        p = randHdr();
        launch(p, 32'd100, 32'd105, '1, 0);
        expMsgQ.push_back({p, 32'd100});
        c = 0;
        while (!sha_begin && c < 50) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort found", found, 0);
        stubLat = 3;
        launch(randHdr(), 32'd200, 32'd203, '1, 1);
        repeat (5) @(negedge clk);
        check("armed busy", busy, 1);
        check("armed hash_count", hash_count, 0);
        waitDone("post-abort done timeout");

        for (int i = 0; i < 25; i++) begin
            salt    = $urandom;
            stubLat = $urandom_range(1, 6);
            s = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 4) : $urandom;
            t = {$urandom, 224'($urandom) ^ (224'($urandom) << 100)};
            if ($urandom_range(0, 3) == 0) begin
                hashMode  = 1;
                stubConst = t - 256'($urandom_range(0, 2)) + 256'd1;
            end else begin
                hashMode = 0;
            end
            launch(randHdr(), s, s + 32'($urandom_range(0, 6)), t, 1);
            waitDone("random done timeout");
        end
        hashMode = 0;

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        nonce_start = 32'd50;
        nonce_end   = 32'd60;
        target      = '1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort+start busy", busy, 0);
        check("abort+start done", done, 0);

`ifdef MINER_TIMEOUT_EN
        begin
            res_t r;
            stubHang = 1'b1;
            p = randHdr();
            launch(p, 32'd1, 32'd1, '1, 0);
            expMsgQ.push_back({p, 32'd1});
            r.fnd = 1'b0; r.n = lastN; r.h = lastH; r.cnt = 0; r.to = 1'b1;
            expResQ.push_back(r);
            c = 0;
            while (!sha_begin && c < 50) begin
                @(negedge clk);
                c++;
            end
            repeat (15) @(negedge clk);
            check("done before timeout", done, 0);
            @(negedge clk);
            check("timeout done", done, 1);
            check("timeout flag", timeout_err, 1);
            stubHang = 1'b0;
        end
`endif

        repeat (10) @(negedge clk);
        check("msg queue drained", expMsgQ.size(), 0);
        check("result queue drained", expResQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        flag("global time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
